// File: rtl/pmod_cls_update_scheduler.sv
// Round-robin owner of the single PMOD CLS display: latches one requester's two lines and
// sequences its commands into the CLS driver. Macro PMOD_CLS_SCHED_CLEAR_EN prepends clear-display.
module pmod_cls_update_scheduler #(
  parameter int unsigned parm_fast_simulation = 0,
  parameter int unsigned FCLK_ce              = 2500000,
  parameter int unsigned parm_holdoff_ms      = 50,
  parameter int unsigned parm_accept_ticks    = 16
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_req_a,
  input  logic [127:0] i_line1_a,
  input  logic [127:0] i_line2_a,
  output logic         o_ack_a,
  output logic         o_done_a,
  input  logic         i_req_b,
  input  logic [127:0] i_line1_b,
  input  logic [127:0] i_line2_b,
  output logic         o_ack_b,
  output logic         o_done_b,
  input  logic         i_command_ready,
  output logic         o_cmd_wr_clear_display,
  output logic         o_cmd_wr_text_line1,
  output logic         o_cmd_wr_text_line2,
  output logic [127:0] o_dat_ascii_line1,
  output logic [127:0] o_dat_ascii_line2,
  output logic         o_busy,
  output logic         o_owner
);

  // Multiply before dividing so a non-integer ce rate in MHz (2.5) keeps its fraction.
  localparam int unsigned HOLD_NORM = (FCLK_ce * parm_holdoff_ms) / 1000 - 1;
  localparam int unsigned HOLD_FAST = (FCLK_ce * parm_holdoff_ms) / 1000000 - 1;
  localparam int unsigned HOLD_LOAD = (parm_fast_simulation != 0) ? HOLD_FAST : HOLD_NORM;
  localparam int unsigned HOLD_W    = (HOLD_NORM > 1) ? $clog2(HOLD_NORM) : 1;
  localparam int unsigned ACC_W     = $clog2(parm_accept_ticks + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_ACCEPT, ST_WAIT_READY, ST_HOLDOFF
  } t_state;

  typedef enum logic [1:0] {STEP_CLEAR, STEP_LINE1, STEP_LINE2} t_step;

`ifdef PMOD_CLS_SCHED_CLEAR_EN
  localparam t_step STEP_FIRST = STEP_CLEAR;
`else
  localparam t_step STEP_FIRST = STEP_LINE1;
`endif

  t_state              r_state, w_state_nxt;
  t_step               r_step, w_step_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
  logic [ACC_W-1:0]    r_acc_cnt, w_acc_nxt;
  logic                w_grant, w_pick, w_done;
  logic                r_last, r_owner, r_busy;
  logic                r_ack_a, r_ack_b, r_done_a, r_done_b;
  logic                r_cmd_line1, r_cmd_line2;
  logic [127:0]        r_line1, r_line2;

  // Next-state, counters and the grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_hold_nxt  = r_hold_cnt;
    w_acc_nxt   = r_acc_cnt;
    w_grant     = 1'b0;
    w_pick      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_ce_2_5mhz && i_command_ready && (i_req_a || i_req_b)) begin
          w_grant     = 1'b1;
          w_pick      = (i_req_a && i_req_b) ? ~r_last : i_req_b;
          w_step_nxt  = STEP_FIRST;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_ce_2_5mhz && i_command_ready) begin
          w_acc_nxt   = '0;
          w_state_nxt = ST_WAIT_ACCEPT;
        end
      end
      ST_WAIT_ACCEPT: begin
        if (i_ce_2_5mhz) begin
          if (!i_command_ready || (r_acc_cnt == ACC_W'(parm_accept_ticks - 1))) begin
            w_state_nxt = ST_WAIT_READY;
          end else begin
            w_acc_nxt = r_acc_cnt + ACC_W'(1);
          end
        end
      end
      ST_WAIT_READY: begin
        if (i_ce_2_5mhz && i_command_ready) begin
          if (r_step == STEP_LINE2) begin
            w_done      = 1'b1;
            w_hold_nxt  = HOLD_W'(HOLD_LOAD);
            w_state_nxt = ST_HOLDOFF;
          end else begin
            w_step_nxt  = (r_step == STEP_LINE1) ? STEP_LINE2 : STEP_LINE1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (i_ce_2_5mhz) begin
          if (r_hold_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_hold_nxt = r_hold_cnt - HOLD_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched text and registered outputs.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_state     <= ST_IDLE;
      r_step      <= STEP_FIRST;
      r_hold_cnt  <= '0;
      r_acc_cnt   <= '0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_busy      <= 1'b0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_cmd_line1 <= 1'b0;
      r_cmd_line2 <= 1'b0;
      r_line1     <= '0;
      r_line2     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_acc_cnt   <= w_acc_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_ack_a     <= w_grant & ~w_pick;
      r_ack_b     <= w_grant & w_pick;
      r_done_a    <= w_done & ~r_owner;
      r_done_b    <= w_done & r_owner;
      r_cmd_line1 <= (w_state_nxt == ST_ISSUE) && (w_step_nxt == STEP_LINE1);
      r_cmd_line2 <= (w_state_nxt == ST_ISSUE) && (w_step_nxt == STEP_LINE2);
      if (w_grant) begin
        r_owner <= w_pick;
        r_last  <= w_pick;
        r_line1 <= w_pick ? i_line1_b : i_line1_a;
        r_line2 <= w_pick ? i_line2_b : i_line2_a;
      end
    end
  end

`ifdef PMOD_CLS_SCHED_CLEAR_EN
  logic r_cmd_clear;

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_cmd_clear <= 1'b0;
    end else begin
      r_cmd_clear <= (w_state_nxt == ST_ISSUE) && (w_step_nxt == STEP_CLEAR);
    end
  end

  assign o_cmd_wr_clear_display = r_cmd_clear;
`else
  assign o_cmd_wr_clear_display = 1'b0;
`endif

  assign o_ack_a             = r_ack_a;
  assign o_ack_b             = r_ack_b;
  assign o_done_a            = r_done_a;
  assign o_done_b            = r_done_b;
  assign o_cmd_wr_text_line1 = r_cmd_line1;
  assign o_cmd_wr_text_line2 = r_cmd_line2;
  assign o_dat_ascii_line1   = r_line1;
  assign o_dat_ascii_line2   = r_line2;
  assign o_busy              = r_busy;
  assign o_owner             = r_owner;

endmodule

// File: tb/tb_pmod_cls_update_scheduler.sv
// Scoreboard bench for pmod_cls_update_scheduler: a round-robin reference model queues expected
// updates; a monitor checks acks, command order, done pulses and hold-off timing.
`timescale 1ns/1ps
module tb_pmod_cls_update_scheduler;
  localparam int unsigned HOLD_TICKS   = 125;  // 50 us at 2.5 ce ticks per us
  localparam int unsigned ACCEPT_TICKS = 16;
`ifdef PMOD_CLS_SCHED_CLEAR_EN
  localparam int NCMD = 3;
  localparam int FIRST_CMD = 0;
`else
  localparam int NCMD = 2;
  localparam int FIRST_CMD = 1;
`endif

  typedef struct packed {
    logic         owner;
    logic [127:0] l1;
    logic [127:0] l2;
  } exp_t;

  logic clk = 1'b0;
  logic rst, ce, req_a, req_b, drv_rdy, force_low, cmd_ready;
  logic [127:0] la1, la2, lb1, lb2;
  logic ack_a, ack_b, done_a, done_b, cmd_clr, cmd_l1, cmd_l2, busy, owner;
  logic [127:0] dat1, dat2;

  int unsigned tick_cnt = 0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  bit model_last;
  bit nodrop, exact_gap;
  int ack_seen = 0;
  int done_seen = 0;
  int unsigned ack_tick, done_tick, rise_tick;

  assign cmd_ready = drv_rdy & ~force_low;

  pmod_cls_update_scheduler #(.parm_fast_simulation(1)) dut (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_ce_2_5mhz(ce),
    .i_req_a(req_a), .i_line1_a(la1), .i_line2_a(la2), .o_ack_a(ack_a), .o_done_a(done_a),
    .i_req_b(req_b), .i_line1_b(lb1), .i_line2_b(lb2), .o_ack_b(ack_b), .o_done_b(done_b),
    .i_command_ready(cmd_ready), .o_cmd_wr_clear_display(cmd_clr),
    .o_cmd_wr_text_line1(cmd_l1), .o_cmd_wr_text_line2(cmd_l2),
    .o_dat_ascii_line1(dat1), .o_dat_ascii_line2(dat2), .o_busy(busy), .o_owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    int div;
    ce = 1'b0;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      ce = (div == 0);
    end
  end

  always @(posedge clk) if (ce) tick_cnt <= tick_cnt + 1;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference arbiter: both asking -> the one not served last; otherwise whoever asks.
  function automatic void push_exp(input bit pa, input bit pb);
    exp_t e;
    bit o;
    o = (pa && pb) ? ~model_last : pb;
    model_last = o;
    e.owner = o;
    e.l1 = o ? lb1 : la1;
    e.l2 = o ? lb2 : la2;
    exp_q.push_back(e);
  endfunction

  // Driver model: ready drops 2 ce after a command is taken, stays low a few ticks, then recovers.
  initial begin
    int unsigned t0;
    int lo, n;
    drv_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (!nodrop && !rst && (cmd_clr || cmd_l1 || cmd_l2)) begin
        n = 0;
        while ((cmd_clr || cmd_l1 || cmd_l2) && !rst && n < 2000) begin
          @(negedge clk);
          n++;
        end
        t0 = tick_cnt;
        while (tick_cnt < t0 + 2) @(negedge clk);
        drv_rdy = 1'b0;
        lo = $urandom_range(2, 5);
        t0 = tick_cnt;
        while (tick_cnt < t0 + lo) @(negedge clk);
        drv_rdy = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each ack and follows the update to its done pulse.
  always @(negedge clk) begin
    logic [2:0] cmdv, rise;
    static logic [2:0] prev_cmd = '0;
    static bit prev_ack = 0;
    static bit in_upd = 0;
    static bit have_done = 0;
    static int cmd_idx = 0;
    static exp_t cur = '0;
    int code;
    cmdv = {cmd_l2, cmd_l1, cmd_clr};
    if (rst) begin
      in_upd = 0;
      have_done = 0;
      prev_ack = 0;
      cmdv = '0;
    end else begin
      if (cmdv != 3'b000) check($countones(cmdv) == 1, "cmd_onehot", cmdv, 1);
      if (ack_a || ack_b) begin
        check(!(ack_a && ack_b), "ack_exclusive", {ack_b, ack_a}, 1);
        check(!prev_ack, "ack_single_cycle", prev_ack, 0);
        check(busy, "busy_after_ack", busy, 1);
        check(exp_q.size() != 0, "ack_expected", {ack_b, ack_a}, 0);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check(ack_b == cur.owner, "ack_owner", ack_b, cur.owner);
          check(owner == cur.owner, "o_owner", owner, cur.owner);
          check(dat1 == cur.l1, "latched_line1", dat1, cur.l1);
          check(dat2 == cur.l2, "latched_line2", dat2, cur.l2);
          if (have_done) begin
            check(tick_cnt - done_tick >= HOLD_TICKS + 1, "holdoff_min",
                  tick_cnt - done_tick, HOLD_TICKS + 1);
            if (exact_gap)
              check(tick_cnt - done_tick == HOLD_TICKS + 1, "holdoff_exact",
                    tick_cnt - done_tick, HOLD_TICKS + 1);
          end
          in_upd = 1;
          cmd_idx = 0;
        end
        ack_tick = tick_cnt;
        ack_seen++;
      end
      prev_ack = ack_a || ack_b;
      rise = cmdv & ~prev_cmd;
      if (rise != 3'b000) begin
        code = rise[0] ? 0 : (rise[1] ? 1 : 2);
        check(in_upd, "cmd_inside_update", code, 0);
        if (in_upd) begin
          check(code == FIRST_CMD + cmd_idx, "cmd_order", code, FIRST_CMD + cmd_idx);
          if (code == 1) check(dat1 == cur.l1, "cmd_line1_data", dat1, cur.l1);
          if (code == 2) check(dat2 == cur.l2, "cmd_line2_data", dat2, cur.l2);
          if (nodrop && cmd_idx > 0)
            check(tick_cnt - rise_tick == ACCEPT_TICKS + 2, "accept_timeout_gap",
                  tick_cnt - rise_tick, ACCEPT_TICKS + 2);
          rise_tick = tick_cnt;
          cmd_idx++;
        end
      end
      if (done_a || done_b) begin
        check(in_upd, "done_expected", {done_b, done_a}, 0);
        if (in_upd) begin
          check(done_b == cur.owner, "done_owner", done_b, cur.owner);
          check(cmd_idx == NCMD, "cmds_per_update", cmd_idx, NCMD);
          check(dat1 == cur.l1 && dat2 == cur.l2, "text_stable_to_done", dat1, cur.l1);
        end
        in_upd = 0;
        have_done = 1;
        done_tick = tick_cnt;
        done_seen++;
      end
    end
    prev_cmd = cmdv;
  end

  task automatic wait_acks(input int tgt);
    for (int c = 0; c < 5000 && ack_seen < tgt; c++) @(negedge clk);
    check(ack_seen >= tgt, "ack_wait", ack_seen, tgt);
  endtask

  task automatic wait_dones(input int tgt);
    for (int c = 0; c < 8000 && done_seen < tgt; c++) @(negedge clk);
    check(done_seen >= tgt, "done_wait", done_seen, tgt);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int c = 0; c < 5000 && busy; c++) @(negedge clk);
    check(!busy, "idle_wait", busy, 0);
  endtask

  task automatic wait_ticks(input int n);
    int unsigned t0;
    t0 = tick_cnt;
    while (tick_cnt < t0 + n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check(!ack_a && !ack_b, {tag, "_ack"}, {ack_b, ack_a}, 0);
    check(!done_a && !done_b, {tag, "_done"}, {done_b, done_a}, 0);
    check({cmd_clr, cmd_l1, cmd_l2} == 3'b000, {tag, "_cmd"}, {cmd_clr, cmd_l1, cmd_l2}, 0);
    check(dat1 == '0, {tag, "_dat1"}, dat1, 0);
    check(dat2 == '0, {tag, "_dat2"}, dat2, 0);
    check(!busy, {tag, "_busy"}, busy, 0);
    check(!owner, {tag, "_owner"}, owner, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    model_last = 1'b1;
    exp_q.delete();
  endtask

  // k grants with the given requests held; dropped (and text scrambled) after the last ack.
  task automatic run_updates(input bit pa, input bit pb, input int k);
    int a0, d0;
    a0 = ack_seen;
    d0 = done_seen;
    for (int i = 0; i < k; i++) push_exp(pa, pb);
    @(negedge clk);
    req_a = pa;
    req_b = pb;
    wait_acks(a0 + 1);
    exact_gap = 1'b1;
    wait_acks(a0 + k);
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    exact_gap = 1'b0;
    la1 = rand_line(); la2 = rand_line(); lb1 = rand_line(); lb2 = rand_line();
    wait_dones(d0 + k);
    wait_idle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0;
    int unsigned t0;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; force_low = 1'b0;
    nodrop = 1'b0; exact_gap = 1'b0; model_last = 1'b1;
    la1 = '0; la2 = '0; lb1 = '0; lb2 = '0;
    do_reset();

    // A alone with a known line.
    la1 = "ACL X:+0012     ";
    la2 = rand_line();
    run_updates(1'b1, 1'b0, 1);

    // Simultaneous from reset: A then B after hold-off.
    do_reset();
    la1 = rand_line(); la2 = rand_line(); lb1 = rand_line(); lb2 = rand_line();
    run_updates(1'b1, 1'b1, 2);

    // Both held: strict alternation.
    run_updates(1'b1, 1'b1, 4);

    // Driver never drops ready: accept timeout path.
    nodrop = 1'b1;
    la1 = rand_line(); lb1 = rand_line();
    run_updates(1'b1, 1'b1, 2);
    nodrop = 1'b0;

    // Ready low blocks the grant; grant on the first tick after it rises.
    force_low = 1'b1;
    lb1 = rand_line(); lb2 = rand_line();
    a0 = ack_seen;
    d0 = done_seen;
    push_exp(1'b0, 1'b1);
    @(negedge clk);
    req_b = 1'b1;
    wait_ticks(30);
    check(ack_seen == a0, "no_ack_while_not_ready", ack_seen - a0, 0);
    force_low = 1'b0;
    t0 = tick_cnt;
    wait_acks(a0 + 1);
    check(ack_tick == t0 + 1, "grant_first_tick_after_ready", ack_tick, t0 + 1);
    req_b = 1'b0;
    wait_dones(d0 + 1);
    wait_idle();

    // Reset while waiting for ready after line1.
    la1 = rand_line(); la2 = rand_line();
    a0 = ack_seen;
    push_exp(1'b1, 1'b0);
    @(negedge clk);
    req_a = 1'b1;
    wait_acks(a0 + 1);
    for (int c = 0; c < 3000 && !cmd_l1; c++) @(negedge clk);
    check(cmd_l1, "line1_issued_before_reset", cmd_l1, 1);
    for (int c = 0; c < 3000 && cmd_ready; c++) @(negedge clk);
    check(!cmd_ready, "driver_busy_before_reset", cmd_ready, 0);
    wait_ticks(1);
    d0 = done_seen;
    rst = 1'b1;
    req_a = 1'b0;
    @(negedge clk);
    check_zero("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    exp_q.delete();
    wait_ticks(40);
    check(done_seen == d0, "no_done_after_abort", done_seen - d0, 0);
    la1 = rand_line(); lb1 = rand_line();
    run_updates(1'b1, 1'b1, 1);

    // Random request patterns.
    for (int i = 0; i < 4; i++) begin
      bit pa, pb;
      int k;
      pa = 1'($urandom_range(0, 1));
      pb = pa ? 1'($urandom_range(0, 1)) : 1'b1;
      k = $urandom_range(1, 2);
      la1 = rand_line(); la2 = rand_line(); lb1 = rand_line(); lb2 = rand_line();
      run_updates(pa, pb, k);
    end

    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmod_cls_update_scheduler.md
Name: pmod_cls_update_scheduler

Overview:
- Shares the single PMOD CLS display between two independent text requesters (A and B).
- Grants the display round-robin and latches the granted requester's two 16-character lines.
- Sequences clear-display, line1 and line2 commands into the CLS custom driver using its command-ready handshake.
- Enforces a minimum hold-off between display updates to limit flicker; sits between application FSMs and pmod_cls_custom_driver.

Parameters:
- parm_fast_simulation, 0, 1 = hold-off counted in microseconds instead of milliseconds.
- FCLK_ce, 2500000, frequency in Hz of i_ce_2_5mhz.
- parm_holdoff_ms, 50, minimum time between end of one update and next grant.
- parm_accept_ticks, 16, number of ce ticks to wait for the driver to drop command-ready after a command is issued.

Ports:
- i_clk_20mhz  in  1  single clock for the block.
- i_rst_20mhz  in  1  reset; synchronous, active-high.
- i_ce_2_5mhz  in  1  clock enable; all FSM and counter state advances only when this is high.
- i_req_a  in  1  requester A level request.
- i_line1_a  in  128  requester A line 1 text (t_pmod_cls_ascii_line_16).
- i_line2_a  in  128  requester A line 2 text.
- o_ack_a  out  1  one-cycle pulse when A is granted and its text is latched.
- o_done_a  out  1  one-cycle pulse when A's update completes.
- i_req_b, i_line1_b, i_line2_b, o_ack_b, o_done_b  as for A.
- i_command_ready  in  1  driver o_command_ready.
- o_cmd_wr_clear_display  out  1  to driver.
- o_cmd_wr_text_line1  out  1  to driver.
- o_cmd_wr_text_line2  out  1  to driver.
- o_dat_ascii_line1  out  128  latched line 1 to driver.
- o_dat_ascii_line2  out  128  latched line 2 to driver.
- o_busy  out  1  high in every state except IDLE.
- o_owner  out  1  owner of the current or last update (0 = A, 1 = B).

Behaviour:
- Reset: all outputs 0; o_dat_* all zero; state IDLE; last-served = B (so A wins the first tie); hold-off counter 0.
- Only one o_cmd_* is ever high at a time.
- States and transitions:
  - IDLE: grant only when at least one request is high and i_command_ready = 1.
    - Both requests high: grant the requester not last served.
    - One request high: grant that requester.
    - On grant: latch lines, set o_owner, pulse o_ack_x for one clk, go to ISSUE.
    - Step = CLEAR if clear is compiled in, else LINE1.
  - ISSUE: drive the step's o_cmd_* high until a ce tick where i_command_ready = 1, then drop it and go to WAIT_ACCEPT. The command is held for at least one ce period.
  - WAIT_ACCEPT: leave on i_command_ready = 0, or after parm_accept_ticks ce ticks (timeout), to WAIT_READY.
  - WAIT_READY: when i_command_ready = 1, advance the step (CLEAR -> LINE1 -> LINE2) and go to ISSUE. After LINE2, pulse o_done_x, load the hold-off counter and go to HOLDOFF.
  - HOLDOFF: decrement once per ce tick; at 0 go to IDLE.
- Hold-off load value:
  - Normal: FCLK_ce/1000*parm_holdoff_ms - 1.
  - Fast simulation: FCLK_ce/1000000*parm_holdoff_ms - 1.
  - Counter width is $clog2 of the normal value.
- Latched text is stable from ack until the next grant. Requester text changes after ack are ignored.
- A request still high after done is served again after hold-off, subject to round-robin.
- A request dropped before grant is never served. A request dropped after ack does not abort the update.
- i_command_ready low in IDLE blocks any grant.
- Reset mid-operation: immediate return to IDLE with reset values. No done pulse is issued for the aborted update.

Optional Feature:
- Macro: PMOD_CLS_SCHED_CLEAR_EN.
- Defined: each update issues clear-display, then line1, then line2 (3 commands).
- Undefined: the CLEAR step and o_cmd_wr_clear_display logic are removed; the output is tied 0 and each update is line1 then line2 (2 commands).

Test Plan:
- A only: i_req_a = 1 with line1 "ACL X:+0012     " -> one o_ack_a pulse, then o_dat_ascii_line1 equals that text. The bench models driver ready dropping 2 ce after each command. Commands appear in order clear, line1, line2 (line1, line2 without the macro), each a single held pulse, then o_done_a.
- Simultaneous A and B requests from reset -> A granted first. B is granted only after the hold-off (125000 ce ticks, or 125 with fast simulation); o_owner reads 0 then 1.
- Both requests held high continuously -> grants alternate A, B, A, B; no requester is granted twice in a row.
- Driver ready never drops after a command -> WAIT_ACCEPT times out after 16 ce ticks and the sequence still completes with o_done.
- i_command_ready held 0 while i_req_b = 1 -> no ack until ready rises; grant occurs on the first ce tick after it does.
- Reset asserted during WAIT_READY of line1 -> next clk: all outputs 0, o_busy = 0, no o_done; a new request afterwards is granted to A first.
